// File: rtl/avalon_tester_pkg.sv
// Shared types and helpers for the SDRAM bring-up
// Avalon-MM self-test master.
package avalon_tester_pkg;

  localparam int ADDR_W_DEF = 26;
  localparam int DATA_W_DEF = 32;
  localparam int IDX_W      = 24;
  localparam int ERR_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic logic [31:0] pat(
    input logic [31:0]      s,
    input logic [IDX_W-1:0] idx
  );
    return s ^ {~idx[7:0], idx};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(
    input logic [ERR_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/avalon_rd_tracker.sv
// Read-side bookkeeping: outstanding count, return index,
// registered compare and first-error capture.
module avalon_rd_tracker
  import avalon_tester_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_PEND = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              acc_i,
  input  logic              rdv_i,
  input  logic [31:0]       rdata_i,
  input  logic [31:0]       seed_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic              can_issue_o,
  output logic              drained_o,
  output logic [ERR_W-1:0]  err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  logic [4:0]        pend_q;
  logic [4:0]        pend_d;
  logic [IDX_W-1:0]  ri_q;
  logic              cmp_vld_q;
  logic [31:0]       cmp_data_q;
  logic [IDX_W-1:0]  cmp_idx_q;
  logic [ERR_W-1:0]  err_q;
  logic [ADDR_W-1:0] ferr_q;
  logic              rdv;
  logic              miss;

  assign rdv  = en_i & rdv_i;
  assign miss = cmp_vld_q &
                (cmp_data_q != pat(seed_i, cmp_idx_q));

  always_comb begin
    pend_d = pend_q;
    unique case ({acc_i, rdv})
      2'b10: pend_d = pend_q + 5'd1;
      2'b01: if (pend_q != '0) pend_d = pend_q - 5'd1;
      default: pend_d = pend_q;
    endcase
  end

  // Gate on post-edge count so a held read never overshoots
  assign can_issue_o = pend_d < 5'(MAX_PEND);
  assign drained_o   = (pend_q == '0) & ~cmp_vld_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q     <= '0;
      ri_q       <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_data_q <= '0;
      cmp_idx_q  <= '0;
      err_q      <= '0;
      ferr_q     <= '0;
    end else if (clr_i) begin
      pend_q    <= '0;
      ri_q      <= '0;
      cmp_vld_q <= 1'b0;
      err_q     <= '0;
      ferr_q    <= '0;
    end else begin
      pend_q    <= pend_d;
      cmp_vld_q <= rdv;
      if (rdv) begin
        cmp_data_q <= rdata_i;
        cmp_idx_q  <= ri_q;
        ri_q       <= ri_q + 1'b1;
      end
      if (miss) begin
        err_q <= sat_inc(err_q);
        if (err_q == '0)
          ferr_q <= base_i +
                    ADDR_W'({cmp_idx_q, 2'b00});
      end
    end
  end

  assign err_count_o      = err_q;
  assign first_err_addr_o = ferr_q;

endmodule

// File: rtl/avalon_mem_tester.sv
// SDRAM self-test master: pattern fill, pipelined
// read-back, pass/fail with error count and first address.
module avalon_mem_tester
  import avalon_tester_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_PEND = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [23:0]       word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [3:0]        avm_byteenable,
  output logic              avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  wi_q;
  logic [IDX_W-1:0]  qi_q;
  logic [31:0]       seed_q;
  logic [31:0]       wdata_q;
  logic              wr_q;
  logic              rd_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;

  logic [ADDR_W-1:0] base_al;
  logic [IDX_W-1:0]  last_idx;
  logic [IDX_W-1:0]  wi_nxt;
  logic [IDX_W-1:0]  qi_nxt;
  logic              acc;
  logic              trk_en;
  logic              clr;
  logic              can_issue;
  logic              drained;
  logic [ERR_W-1:0]  err_w;
  logic [ADDR_W-1:0] ferr_w;

  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [ADDR_W-1:0] b,
    input logic [IDX_W-1:0]  i
  );
    return b + ADDR_W'({i, 2'b00});
  endfunction

  assign base_al  = base_addr & ~ADDR_W'(3);
  assign last_idx = cnt_q - 1'b1;
  assign wi_nxt   = wi_q + 1'b1;
  assign qi_nxt   = qi_q + 1'b1;
  assign acc      = rd_q & ~avm_waitrequest;
  assign trk_en   = (state_q == S_RD) |
                    (state_q == S_DRAIN);
  assign clr      = (state_q == S_IDLE) & start;

  avalon_rd_tracker #(
    .ADDR_W   (ADDR_W),
    .MAX_PEND (MAX_PEND)
  ) u_trk (
    .clk_i            (clk_clk),
    .rst_i            (reset_reset),
    .clr_i            (clr),
    .en_i             (trk_en),
    .acc_i            (acc),
    .rdv_i            (avm_readdatavalid),
    .rdata_i          (avm_readdata),
    .seed_i           (seed_q),
    .base_i           (base_q),
    .can_issue_o      (can_issue),
    .drained_o        (drained),
    .err_count_o      (err_w),
    .first_err_addr_o (ferr_w)
  );

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      wi_q    <= '0;
      qi_q    <= '0;
      seed_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q  <= base_al;
            cnt_q   <= word_count;
            seed_q  <= seed;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            wi_q    <= '0;
            addr_q  <= base_al;
            wdata_q <= pat(seed, IDX_W'(0));
            if (word_count == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_WR;
              wr_q    <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (!avm_waitrequest) begin
            if (wi_q == last_idx) begin
              wr_q    <= 1'b0;
              rd_q    <= 1'b1;
              qi_q    <= '0;
              addr_q  <= base_q;
              state_q <= S_RD;
            end else begin
              wi_q    <= wi_nxt;
              addr_q  <= addr_of(base_q, wi_nxt);
              wdata_q <= pat(seed_q, wi_nxt);
            end
          end
        end
        S_RD: begin
          if (acc) begin
            if (qi_q == last_idx) begin
              rd_q    <= 1'b0;
              state_q <= S_DRAIN;
            end else begin
              qi_q   <= qi_nxt;
              addr_q <= addr_of(base_q, qi_nxt);
              rd_q   <= can_issue;
            end
          end else if (!rd_q) begin
            rd_q <= can_issue;
          end
        end
        S_DRAIN: begin
          if (drained) state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          pass_q  <= (err_w == '0);
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_w;
  assign first_err_addr = ferr_w;
  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'hF;
  assign avm_burstcount = 1'b1;

endmodule

// File: doc/avalon_mem_tester.md
# avalon_mem_tester

Avalon-MM master that drives the 32-bit SDRAM bridge slave (26-bit byte address, burstcount 1) directly upstream of the SDRAM controller. On `start` it fills a word region with a deterministic pattern, then reads it back with pipelined reads and compares each word. It reports pass/fail, an error count and the first failing address. This block is the bring-up and self-test master for the SDRAM subsystem.

## Interface
- `ADDR_W`, 26: Avalon byte-address width.
- `DATA_W`, 32: Avalon data width; fixed at 32.
- `MAX_PEND`, 8: maximum outstanding reads, 1..15.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk_clk` input 1: system clock; all logic rises on this edge.
- `reset_reset` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `base_addr` input ADDR_W: region byte base; bits [1:0] are treated as 0. Latched at start.
- `word_count` input 24: number of 32-bit words. Latched at start.
- `seed` input 32: pattern seed. Latched at start.
- `busy` output 1: high from the cycle after start until DONE.
- `done` output 1: one-cycle pulse at test end.
- `pass` output 1: err_count==0 at end; held until next start.
- `err_count` output 16: count of mismatching words; saturates at 16'hFFFF.
- `first_err_addr` output ADDR_W: byte address of the first mismatch; 0 if there is none.
- `avm_address` output ADDR_W: equals base + 4*index, modulo 2^ADDR_W.
- `avm_read`, `avm_write` output 1 each: Avalon commands.
- `avm_writedata` output 32: pattern word.
- `avm_byteenable` output 4: constant 4'hF.
- `avm_burstcount` output 1: constant 1'b1.
- `avm_waitrequest` input 1: slave stall.
- `avm_readdata` input 32: read data.
- `avm_readdatavalid` input 1: read data qualifier.

## Operation
- Pattern: pat(i) = seed ^ {~i[7:0], i[23:0]}, where i is the 24-bit word index.
- States: IDLE, WR, RD, DRAIN, DONE.
- IDLE:
  - On start: latch base_addr, word_count and seed; clear err_count, first_err_addr and pass.
  - If word_count==0, go to DONE; otherwise go to WR with wi=0.
- WR:
  - Drive avm_write=1, address base+4*wi, data pat(wi).
  - A transfer is accepted when avm_waitrequest==0. On acceptance, wi++.
  - Address and data stay stable while waitrequest is high.
  - After the last acceptance (wi==word_count-1), go to RD with issue index qi=0, check index ri=0, pend=0.
- RD:
  - Drive avm_read=1 with address base+4*qi whenever pend<MAX_PEND.
  - Once avm_read is asserted, it is held until accepted, even if pend would otherwise block it.
  - On acceptance: qi++, pend++.
  - After the last read is accepted, go to DRAIN.
- Any state RD or DRAIN, on avm_readdatavalid:
  - Compare readdata against pat(ri).
  - On mismatch: err_count++ (saturating); if it is the first error, capture base+4*ri.
  - Then ri++, pend--.
  - If acceptance and readdatavalid occur in the same cycle, pend is unchanged.
- DRAIN: when pend==0 (and ri==word_count), go to DONE.
- DONE:
  - Assert done for 1 cycle; set pass=(err_count==0); go to IDLE.
- Ignored inputs:
  - start while busy is ignored.
  - readdatavalid in IDLE, WR or DONE is ignored.

## Timing
- Reset values:
  - All outputs are 0, except avm_byteenable=4'hF and avm_burstcount=1.
  - State is IDLE.
- Reset mid-operation:
  - Commands drop in the same cycle; the reset is asynchronous and overrides the Avalon hold rule.
  - pass, err_count and first_err_addr are cleared.
- Start latency: start high at edge N gives busy=1 and the first avm_write at N+1.
- Throughput: one write per cycle, and one read per cycle while pend<MAX_PEND, when waitrequest is low.
- WR to RD: the first avm_read occurs the cycle after the last write is accepted. There is no idle gap beyond that.
- The compare is registered. err_count and first_err_addr update 1 cycle after readdatavalid.
- Final result:
  - DONE is entered no earlier than 2 cycles after the final readdatavalid, so the last compare is included.
  - pass and done are visible in the same cycle.
- Address arithmetic wraps modulo 2^ADDR_W. Indices are 24-bit; pat() uses the full index.

## Structure
- Package `avalon_tester_pkg` holds:
  - the state enum;
  - ADDR_W/DATA_W defaults;
  - the `pat(seed, idx)` function;
  - the saturating-increment helper.
- One sub-module: `avalon_rd_tracker`. It holds the pend counter, the ri counter, the registered compare and the error capture, so the master FSM only issues commands.

## Test plan
- Zero-wait write/read: word_count=16, base=0x100, seed=0xA5A5A5A5, waitrequest=0, readdatavalid 2 cycles after each read.
  - Required: 16 writes at 0x100..0x13C, 16 reads, pass=1, err_count=0.
  - Done occurs ≤40 cycles after start.
- Random waitrequest (50%) with MAX_PEND=8 and a fixed read latency of 10:
  - Never more than 8 reads are outstanding.
  - Address and data are stable while stalled.
  - pass=1.
- Fault injection: the slave model flips bit 0 of word 5 and all of word 9 (count=32, base=0).
  - Required: err_count=2, first_err_addr=0x14, pass=0.
- Boundaries:
  - word_count=0: done 2 cycles after start, pass=1, no bus activity.
  - base=0x3FFFFFC, count=2: second access at address 0x0000000.
- Simultaneous acceptance and readdatavalid every cycle: pend stays constant and the final result is correct.
- Reset asserted during RD with 5 reads pending:
  - Outputs clear immediately.
  - Stale readdatavalid after reset does not change err_count.
  - A new start runs cleanly to pass=1.
